// File: rtl/cla_share_arbiter.sv
// Round-robin sequencer that time-shares one combinational WIDTH-bit adder among
// four requesters: latch winner's operands, capture sum/carry, hand back a tagged result.
module cla_share_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_bus,
  input  logic [4*WIDTH-1:0] b_bus,
  input  logic [3:0]         cin_bus,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [1:0]         res_id,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_cout,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] win;

  // First requester found scanning ptr, ptr+1, ... (2-bit index wraps mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign win = rr_pick(req, ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'd0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 2'd0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt <= 4'd0;
      case (state)
        IDLE: begin
          if (|req) begin
            add_a   <= a_bus[win*WIDTH +: WIDTH];
            add_b   <= b_bus[win*WIDTH +: WIDTH];
            add_cin <= cin_bus[win];
            res_id  <= win;
            gnt     <= 4'b0001 << win;
            ptr     <= win + 2'd1;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        // Operands have been stable on the adder for a full cycle; take its result.
        EXEC: begin
          res_sum   <= add_sum;
          res_cout  <= add_cout;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Bench for cla_share_arbiter: directed scenarios plus random traffic, results
// scoreboarded against a cycle-level round-robin model.
module tb_cla_share_arbiter;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req = 4'd0;
  logic [4*W-1:0] a_bus = '0;
  logic [4*W-1:0] b_bus = '0;
  logic [3:0]     cin_bus = 4'd0;
  logic [3:0]     gnt;
  logic [W-1:0]   add_a, add_b, add_sum, res_sum;
  logic           add_cin, add_cout, res_valid, res_cout, busy;
  logic           res_ready = 1'b1;
  logic [1:0]     res_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // The shared combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  cla_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus), .cin_bus(cin_bus),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout), .busy(busy)
  );

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  res_t       sb[$];
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_ptr = 0;
  int         acc_cyc = 0;
  logic [1:0] m_win = 2'd0;
  logic [3:0] exp_gnt = 4'd0;
  bit         exp_valid = 1'b0;
  int         glog_id[$];
  int         glog_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted request owns the adder until its result is consumed;
  // gnt is seen the cycle after acceptance, the result the cycle after that.
  initial begin
    logic [1:0] idx;
    logic [W:0] full;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy = 1'b0;
        m_ptr  = 0;
        sb.delete();
      end else if (!m_busy) begin
        if (req != 4'd0) begin
          for (int k = 0; k < 4; k++) begin
            idx = 2'((m_ptr + k) % 4);
            if (req[idx]) begin
              m_win = idx;
              break;
            end
          end
          full = {1'b0, a_bus[m_win*W +: W]} + {1'b0, b_bus[m_win*W +: W]}
               + {{W{1'b0}}, cin_bus[m_win]};
          sb.push_back('{id: m_win, sum: full[W-1:0], cout: full[W]});
          m_ptr   = (int'(m_win) + 1) % 4;
          m_busy  = 1'b1;
          acc_cyc = cyc;
        end
      end else if (cyc >= acc_cyc + 2 && res_ready) begin
        m_busy = 1'b0;
      end
      exp_gnt   = (m_busy && cyc == acc_cyc) ? (4'b0001 << m_win) : 4'd0;
      exp_valid = m_busy && (cyc >= acc_cyc + 1);
    end
  end

  // Monitor: per-cycle control checks and result scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      for (int i = 0; i < 4; i++) begin
        if (gnt[2'(i)]) begin
          glog_id.push_back(i);
          glog_cyc.push_back(cyc);
        end
      end
      if (res_valid) begin
        chk("result_expected", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          chk("res_id", 32'(res_id), 32'(sb[0].id));
          chk("res_sum", 32'(res_sum), 32'(sb[0].sum));
          chk("res_cout", 32'(res_cout), 32'(sb[0].cout));
          if (res_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
    cin_bus[2'(i)]  = c;
  endtask

  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    while (!gnt[2'(i)] && n < 30) begin
      tick();
      n++;
    end
    chk($sformatf("gnt_seen_%0d", i), 32'(gnt[2'(i)]), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_add_a"}, 32'(add_a), 32'd0);
    chk({tag, "_add_b"}, 32'(add_b), 32'd0);
    chk({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    chk({tag, "_res_id"}, 32'(res_id), 32'd0);
    chk({tag, "_res_sum"}, 32'(res_sum), 32'd0);
    chk({tag, "_res_cout"}, 32'(res_cout), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    int exp_id[5];

    res_ready = 1'b1;
    do_reset();
    chk_cleared("reset");

    // Single request, no backpressure.
    set_op(0, 16'h1234, 16'h0001, 1'b0);
    req = 4'b0001;
    wait_gnt(0);
    chk("t1_gnt", 32'(gnt), 32'h1);
    req = 4'd0;
    tick();
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_sum", 32'(res_sum), 32'h1235);
    chk("t1_cout", 32'(res_cout), 32'd0);
    chk("t1_id", 32'(res_id), 32'd0);
    repeat (2) tick();

    // Overflow with carry-in.
    set_op(2, 16'hFFFF, 16'h0000, 1'b1);
    req = 4'b0100;
    wait_gnt(2);
    req = 4'd0;
    tick();
    chk("t2_sum", 32'(res_sum), 32'h0000);
    chk("t2_cout", 32'(res_cout), 32'd1);
    chk("t2_id", 32'(res_id), 32'd2);
    repeat (2) tick();

    // Fairness: all four held high straight after reset.
    do_reset();
    glog_id.delete();
    glog_cyc.delete();
    for (int i = 0; i < 4; i++) set_op(i, W'(16'h1000 * (i + 1)), W'(i), 1'b0);
    req = 4'b1111;
    repeat (16) tick();
    req = 4'd0;
    repeat (4) tick();
    exp_id = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fair_order_%0d", k), 32'((k < glog_id.size()) ? glog_id[k] : 99),
          32'(exp_id[k]));
      if (k > 0)
        chk($sformatf("fair_space_%0d", k),
            32'((k < glog_cyc.size()) ? glog_cyc[k] - glog_cyc[k-1] : 99), 32'd3);
    end

    // Backpressure: result held while requester 1 waits.
    res_ready = 1'b0;
    set_op(0, 16'hABCD, 16'h1111, 1'b1);
    req = 4'b0001;
    wait_gnt(0);
    req = 4'b0010;
    set_op(1, 16'h0F0F, 16'hF0F1, 1'b0);
    tick();
    held = res_sum;
    chk("bp_first_sum", 32'(held), 32'h BCDF);
    repeat (5) begin
      tick();
      chk("bp_hold_sum", 32'(res_sum), 32'(held));
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_no_gnt", 32'(gnt), 32'd0);
    end
    res_ready = 1'b1;
    wait_gnt(1);
    req = 4'd0;
    repeat (3) tick();

    // Pointer wrap: after requester 3, 0 beats 3; then ptr=1 makes 1 beat 0 and 3.
    do_reset();
    set_op(3, 16'h7FFF, 16'h0001, 1'b0);
    req = 4'b1000;
    wait_gnt(3);
    req = 4'd0;
    repeat (2) tick();
    set_op(0, 16'h0002, 16'h0003, 1'b1);
    req = 4'b1001;
    wait_gnt(0);
    chk("wrap_winner", 32'(gnt), 32'h1);
    set_op(1, 16'h8000, 16'h8000, 1'b0);
    req = 4'b1011;
    wait_gnt(1);
    chk("wrap_ptr1_winner", 32'(gnt), 32'h2);
    req = 4'b1001;
    wait_gnt(3);
    req = 4'b0001;
    wait_gnt(0);
    req = 4'd0;
    repeat (3) tick();

    // Reset during EXEC discards the operation.
    set_op(2, 16'h5555, 16'hAAAA, 1'b1);
    req = 4'b0100;
    wait_gnt(2);
    req = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cleared("midrst");
    repeat (3) tick();
    set_op(3, 16'h0100, 16'h0200, 1'b0);
    req = 4'b1000;
    wait_gnt(3);
    req = 4'd0;
    repeat (3) tick();

    // Random traffic with random backpressure.
    repeat (600) begin
      for (int i = 0; i < 4; i++) begin
        if (req[2'(i)] && gnt[2'(i)]) begin
          req[2'(i)] = 1'b0;
        end else if (!req[2'(i)] && $urandom_range(3) == 0) begin
          set_op(i, ($urandom_range(3) == 0) ? 16'hFFFF : W'($urandom),
                 W'($urandom), 1'($urandom));
          req[2'(i)] = 1'b1;
        end
      end
      res_ready = ($urandom_range(2) != 0);
      tick();
    end

    // Drain.
    res_ready = 1'b1;
    for (int n = 0; n < 60 && req != 4'd0; n++) begin
      for (int i = 0; i < 4; i++)
        if (gnt[2'(i)]) req[2'(i)] = 1'b0;
      tick();
    end
    req = 4'd0;
    repeat (5) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
